parity_cycle_ctl: RTL

Memory-cycle sequencer for the parity/S-register datapath. It accepts one read or write request at a time and drives the memory port through its address/read/restore/write phases. On writes it generates the odd-parity bit carried on G16. On reads it checks parity, reports failures and keeps a sticky parity alarm. Erasable locations are read destructively, so the block automatically schedules the restore write for them.

---
 rtl/parity_cycle_ctl.sv | 204 ++++++++++++++++++++
 1 files changed

// File: rtl/parity_cycle_ctl.sv
`default_nettype none
// ============================================================================
// Module      : parity_cycle_ctl
// Description : Memory-cycle sequencer for the parity/S-register datapath.
//               Accepts one read or write request at a time and drives the
//               memory port through address/read/restore/write phases.
//               Writes carry a generated odd-parity bit on G16; reads are
//               parity-checked, with a sticky alarm and a saturating error
//               count. Erasable locations are read destructively, so every
//               erasable read is followed by an automatic restore write.
// Ports       : CLOCK, rst              - clock, synchronous active-high reset
//               REQ, RD, ADDR, WDATA    - requester side, held until DONE
//               MONPAR, ALARM_CLR       - parity test mode, alarm clear
//               MEM_ACK, MEM_RDATA      - memory phase completion / read word
//               MEM_REQ, MEM_WE,
//               MEM_ADDR, MEM_WDATA     - memory phase request
//               BUSY, DONE, RDATA,
//               PAR_ERR, WERR, TMO      - completion status (pulses with DONE)
//               PALE, PERR_CNT          - sticky alarm, saturating error count
// Revision    : 1.0 - initial release
// ============================================================================
module parity_cycle_ctl #(
    parameter int         TMO_CYC  = 15,
    parameter logic [1:0] EB_LIMIT = 2'b00
) (
    input  logic        CLOCK,
    input  logic        rst,
    input  logic        REQ,
    input  logic        RD,
    input  logic [11:0] ADDR,
    input  logic [14:0] WDATA,
    input  logic        MONPAR,
    input  logic        ALARM_CLR,
    input  logic        MEM_ACK,
    input  logic [15:0] MEM_RDATA,
    output logic        MEM_REQ,
    output logic        MEM_WE,
    output logic [11:0] MEM_ADDR,
    output logic [15:0] MEM_WDATA,
    output logic        BUSY,
    output logic        DONE,
    output logic [14:0] RDATA,
    output logic        PAR_ERR,
    output logic        WERR,
    output logic        TMO,
    output logic        PALE,
    output logic [3:0]  PERR_CNT
);

    localparam logic [2:0] c_st_idle = 3'd0;
    localparam logic [2:0] c_st_rdp  = 3'd1;
    localparam logic [2:0] c_st_chk  = 3'd2;
    localparam logic [2:0] c_st_rstr = 3'd3;
    localparam logic [2:0] c_st_wrp  = 3'd4;
    localparam logic [2:0] c_st_fin  = 3'd5;

    // The phase is abandoned on the edge where the wait counter would reach
    // TMO_CYC, unless MEM_ACK is present in that same cycle.
    localparam logic [3:0] c_tmo_last = 4'(TMO_CYC - 1);
    localparam logic [3:0] c_cnt_max  = 4'hF;

    logic [2:0]  r_state;
    logic [11:0] r_addr;
    logic [15:0] r_word;      // write word on writes, latched read word on reads
    logic [14:0] r_rdata;
    logic [3:0]  r_tcnt;
    logic        r_perr_flag;
    logic        r_werr_flag;
    logic        r_tmo_flag;
    logic        r_pale;
    logic [3:0]  r_perr_cnt;

    logic        w_req_erasable;
    logic        w_addr_erasable;
    logic        w_tmo_hit;
    logic        w_bad_parity;

    assign w_req_erasable  = (ADDR[11:10] == EB_LIMIT);
    assign w_addr_erasable = (r_addr[11:10] == EB_LIMIT);
    assign w_tmo_hit       = !MEM_ACK && (r_tcnt == c_tmo_last);
    // Odd parity over all 16 bits: a good word XORs to 1.
    assign w_bad_parity    = (r_state == c_st_chk) && !(^r_word);

    // ------------------------------------------------------------------------
    // Sequencer
    // ------------------------------------------------------------------------
    always_ff @(posedge CLOCK) begin
        if (rst) begin
            r_state     <= c_st_idle;
            r_addr      <= 12'd0;
            r_word      <= 16'd0;
            r_rdata     <= 15'd0;
            r_tcnt      <= 4'd0;
            r_perr_flag <= 1'b0;
            r_werr_flag <= 1'b0;
            r_tmo_flag  <= 1'b0;
        end else begin
            case (r_state)
                c_st_idle: begin
                    if (REQ) begin
                        r_perr_flag <= 1'b0;
                        r_werr_flag <= 1'b0;
                        r_tmo_flag  <= 1'b0;
                        r_rdata     <= 15'd0;
                        r_tcnt      <= 4'd0;
                        if (RD) begin
                            r_addr  <= ADDR;
                            r_state <= c_st_rdp;
                        end else if (w_req_erasable) begin
                            r_addr  <= ADDR;
                            r_word  <= {~(^WDATA) ^ MONPAR, WDATA};
                            r_state <= c_st_wrp;
                        end else begin
                            // Fixed memory is read-only: reject without a cycle.
                            r_werr_flag <= 1'b1;
                            r_state     <= c_st_fin;
                        end
                    end
                end

                c_st_rdp: begin
                    if (MEM_ACK) begin
                        r_word  <= MEM_RDATA;
                        r_rdata <= MEM_RDATA[14:0];
                        r_state <= c_st_chk;
                    end else if (w_tmo_hit) begin
                        r_tmo_flag <= 1'b1;
                        r_rdata    <= 15'd0;
                        r_state    <= c_st_fin;
                    end else begin
                        r_tcnt <= r_tcnt + 4'd1;
                    end
                end

                c_st_chk: begin
                    if (w_bad_parity) begin
                        r_perr_flag <= 1'b1;
                    end
                    r_tcnt  <= 4'd0;
                    r_state <= w_addr_erasable ? c_st_rstr : c_st_fin;
                end

                c_st_rstr, c_st_wrp: begin
                    if (MEM_ACK) begin
                        r_state <= c_st_fin;
                    end else if (w_tmo_hit) begin
                        r_tmo_flag <= 1'b1;
                        r_rdata    <= 15'd0;
                        r_state    <= c_st_fin;
                    end else begin
                        r_tcnt <= r_tcnt + 4'd1;
                    end
                end

                c_st_fin: begin
                    r_state <= c_st_idle;
                end

                default: begin
                    r_state <= c_st_idle;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------------
    // Parity alarm and saturating error count (a new failure beats a clear)
    // ------------------------------------------------------------------------
    always_ff @(posedge CLOCK) begin
        if (rst) begin
            r_pale     <= 1'b0;
            r_perr_cnt <= 4'd0;
        end else begin
            if (w_bad_parity) begin
                r_pale <= 1'b1;
            end else if (ALARM_CLR) begin
                r_pale <= 1'b0;
            end
            if (w_bad_parity && (r_perr_cnt != c_cnt_max)) begin
                r_perr_cnt <= r_perr_cnt + 4'd1;
            end
        end
    end

    // ------------------------------------------------------------------------
    // Outputs: registers or decodes of registered state only
    // ------------------------------------------------------------------------
    assign MEM_REQ   = (r_state == c_st_rdp) || (r_state == c_st_rstr) ||
                       (r_state == c_st_wrp);
    assign MEM_WE    = (r_state == c_st_rstr) || (r_state == c_st_wrp);
    assign MEM_ADDR  = r_addr;
    // Restores write back the latched word untouched, bad parity included.
    assign MEM_WDATA = r_word;
    assign BUSY      = (r_state != c_st_idle);
    assign DONE      = (r_state == c_st_fin);
    assign RDATA     = r_rdata;
    assign PAR_ERR   = DONE && r_perr_flag;
    assign WERR      = DONE && r_werr_flag;
    assign TMO       = DONE && r_tmo_flag;
    assign PALE      = r_pale;
    assign PERR_CNT  = r_perr_cnt;

endmodule
`default_nettype wire
